// File: rtl/lsu_pkg.sv
// Load/store unit shared types and widths.
// Imported by the LSU and its bench.
package lsu_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MAX_LEN_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DRAIN,
    WR,
    WR_RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Burst load/store unit in front of a registered-output
// synchronous word memory; one beat per cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_LEN_W = lsu_pkg::MAX_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [MAX_LEN_W-1:0] req_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 resp_valid,
  output logic                 resp_last,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 mem_en,
  output logic                 mem_wen,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_data_in,
  input  logic [DATA_W-1:0]    mem_data_out
);

  lsu_state_t state, state_nxt;

  logic [ADDR_W-1:0]    addr_q;
  logic [MAX_LEN_W-1:0] len_q;
  logic [MAX_LEN_W-1:0] beat_q;
  logic                 pend_q;
  logic                 pend_last_q;
  logic                 at_last;

  assign at_last = (beat_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (req_valid) state_nxt = req_wr ? WR : RD;
      RD:
        if (at_last) state_nxt = RD_DRAIN;
      RD_DRAIN:
        state_nxt = IDLE;
      WR:
        if (wdata_valid && at_last) state_nxt = WR_RESP;
      WR_RESP:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  // pend_q marks a load beat whose data arrives this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= (state == RD);
      pend_last_q <= (state == RD) && at_last;
      unique case (state)
        IDLE:
          if (req_valid) begin
            addr_q <= req_addr;
            len_q  <= req_len;
            beat_q <= '0;
          end
        RD: begin
          addr_q <= addr_q + 1'b1;
          beat_q <= beat_q + 1'b1;
        end
        WR:
          if (wdata_valid) begin
            addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    mem_en      = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    resp_valid  = pend_q;
    resp_last   = pend_q & pend_last_q;
    resp_rdata  = pend_q ? mem_data_out : '0;
    unique case (state)
      IDLE:
        req_ready = 1'b1;
      RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
      end
      WR: begin
        wdata_ready = 1'b1;
        mem_en      = wdata_valid;
        mem_wen     = wdata_valid;
        mem_addr    = addr_q;
        mem_data_in = wdata;
      end
      WR_RESP: begin
        resp_valid = 1'b1;
        resp_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: LSU paired with a 256x32 registered memory.
// Inputs change 1ns after posedge; outputs checked 2ns after.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [1:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_last;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_LEN_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata),
    .resp_valid(resp_valid), .resp_last(resp_last),
    .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always @(posedge clk) begin
    if (mem_en && mem_wen) mem[mem_addr] <= mem_data_in;
    if (mem_en && !mem_wen) mem_data_out <= mem[mem_addr];
    else if (!mem_en) mem_data_out <= '0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [7:0] a;
    rst = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_len = '0;
    wdata_valid = 1'b0;
    wdata = '0;

    tick(); tick();
    settle();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    chk("rst_wrdy", 32'(wdata_ready), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    // single store 0x10 <- DEADBEEF
    tick();
    req_valid = 1'b1; req_wr = 1'b1;
    req_addr = 8'h10; req_len = 2'd0;
    tick();
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 32'hDEADBEEF;
    settle();
    chk("st_wrdy", 32'(wdata_ready), 32'd1);
    chk("st_en", 32'(mem_en), 32'd1);
    chk("st_wen", 32'(mem_wen), 32'd1);
    chk("st_addr", 32'(mem_addr), 32'h10);
    chk("st_din", mem_data_in, 32'hDEADBEEF);
    chk("st_ready", 32'(req_ready), 32'd0);
    tick();
    wdata_valid = 1'b0;
    settle();
    chk("st_resp", 32'(resp_valid), 32'd1);
    chk("st_last", 32'(resp_last), 32'd1);
    chk("st_rdata", resp_rdata, 32'd0);
    chk("st_en_off", 32'(mem_en), 32'd0);
    tick();
    settle();
    chk("st_idle_resp", 32'(resp_valid), 32'd0);
    chk("st_idle_rdy", 32'(req_ready), 32'd1);

    // single load 0x10
    req_valid = 1'b1; req_wr = 1'b0;
    req_addr = 8'h10; req_len = 2'd0;
    tick();
    req_valid = 1'b0;
    settle();
    chk("ld_en", 32'(mem_en), 32'd1);
    chk("ld_wen", 32'(mem_wen), 32'd0);
    chk("ld_addr", 32'(mem_addr), 32'h10);
    chk("ld_early", 32'(resp_valid), 32'd0);
    tick();
    settle();
    chk("ld_resp", 32'(resp_valid), 32'd1);
    chk("ld_rdata", resp_rdata, 32'hDEADBEEF);
    chk("ld_last", 32'(resp_last), 32'd1);
    chk("ld_en_off", 32'(mem_en), 32'd0);
    tick();
    settle();
    chk("ld_done", 32'(resp_valid), 32'd0);
    chk("ld_rdata0", resp_rdata, 32'd0);

    // gapped store burst 0xFE..0x01 <- 1..4
    req_valid = 1'b1; req_wr = 1'b1;
    req_addr = 8'hFE; req_len = 2'd3;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'hFE + 8'(i);
      wdata_valid = 1'b1; wdata = 32'(i + 1);
      settle();
      chk("sb_en", 32'(mem_en & mem_wen), 32'd1);
      chk("sb_addr", 32'(mem_addr), 32'(a));
      chk("sb_din", mem_data_in, 32'(i + 1));
      tick();
      wdata_valid = 1'b0;
      if (i < 3) begin
        settle();
        chk("sb_gap_en", 32'(mem_en), 32'd0);
        chk("sb_gap_wen", 32'(mem_wen), 32'd0);
        chk("sb_gap_rdy", 32'(wdata_ready), 32'd1);
        chk("sb_gap_resp", 32'(resp_valid), 32'd0);
        tick();
      end
    end
    settle();
    chk("sb_resp", 32'(resp_valid), 32'd1);
    chk("sb_last", 32'(resp_last), 32'd1);
    chk("sb_din0", mem_data_in, 32'd0);
    tick();

    // load burst 0xFE len 3
    req_valid = 1'b1; req_wr = 1'b0;
    req_addr = 8'hFE; req_len = 2'd3;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a = 8'hFE + 8'(k);
      settle();
      chk("lb_en", 32'(mem_en), 32'(k < 4));
      if (k < 4) chk("lb_addr", 32'(mem_addr), 32'(a));
      chk("lb_resp", 32'(resp_valid), 32'(k > 0));
      if (k > 0) begin
        chk("lb_rdata", resp_rdata, 32'(k));
        chk("lb_last", 32'(resp_last), 32'(k == 4));
      end
      tick();
    end
    settle();
    chk("lb_done", 32'(resp_valid), 32'd0);
    chk("lb_rdy", 32'(req_ready), 32'd1);

    // reset in 2nd cycle of load burst
    req_valid = 1'b1; req_wr = 1'b0;
    req_addr = 8'hFE; req_len = 2'd3;
    tick();
    req_valid = 1'b0;
    tick();
    settle();
    chk("ra_beat0", 32'(resp_valid), 32'd1);
    chk("ra_addr", 32'(mem_addr), 32'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ra_en", 32'(mem_en), 32'd0);
      chk("ra_resp", 32'(resp_valid), 32'd0);
      chk("ra_rdata", resp_rdata, 32'd0);
      chk("ra_rdy", 32'(req_ready), 32'd1);
      tick();
    end

    // request held high through a burst
    req_valid = 1'b1; req_wr = 1'b0;
    req_addr = 8'hFE; req_len = 2'd1;
    tick();
    req_addr = 8'h10; req_len = 2'd0;
    settle();
    chk("hold_rdy0", 32'(req_ready), 32'd0);
    chk("hold_a0", 32'(mem_addr), 32'hFE);
    tick();
    settle();
    chk("hold_a1", 32'(mem_addr), 32'hFF);
    chk("hold_d1", resp_rdata, 32'd1);
    chk("hold_l1", 32'(resp_last), 32'd0);
    tick();
    settle();
    chk("hold_d2", resp_rdata, 32'd2);
    chk("hold_l2", 32'(resp_last), 32'd1);
    chk("hold_en2", 32'(mem_en), 32'd0);
    chk("hold_rdy2", 32'(req_ready), 32'd0);
    tick();
    settle();
    chk("hold_rdy3", 32'(req_ready), 32'd1);
    chk("hold_en3", 32'(mem_en), 32'd0);
    tick();
    req_valid = 1'b0;
    settle();
    chk("hold_b_en", 32'(mem_en), 32'd1);
    chk("hold_b_addr", 32'(mem_addr), 32'h10);
    tick();
    settle();
    chk("hold_b_resp", 32'(resp_valid), 32'd1);
    chk("hold_b_data", resp_rdata, 32'hDEADBEEF);
    chk("hold_b_last", 32'(resp_last), 32'd1);
    tick();
    settle();
    chk("hold_b_idle", 32'(req_ready), 32'd1);
    chk("hold_b_quiet", 32'(resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
